prbs_xor_gen_chk: RTL and testbench



---
 rtl/prbs_xor_gen_chk.sv | 154 +++++++++++++++
 tb/tb_prbs_xor_gen_chk.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_xor_gen_chk.sv
// prbs_xor_gen_chk -- N-tap XOR-feedback LFSR used as a PRBS generator or as a
// self-synchronising PRBS checker for BIST on serial test paths.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         step enable; the LFSR advances only when en=1
//   mode       0 = generator, 1 = checker (sampled only in IDLE)
//   start      one-cycle pulse: leaves IDLE, or returns to IDLE when busy
//   seed_load  loads seed into the LFSR (IDLE/GEN only)
//   seed       generator seed, WIDTH bits
//   din        serial PRBS input for the checker
//   dout       registered generator output bit
//   locked     checker is in LOCKED
//   err        one-cycle pulse on a counted mismatch
//   err_cnt    saturating error count, CNT_W bits
//   busy       state != IDLE
module prbs_xor_gen_chk #(
  parameter int              WIDTH    = 7,
  parameter logic [WIDTH-1:0] TAPS    = 7'h60,
  parameter int              CNT_W    = 16,
  parameter int              LOSS_THR = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             start,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             din,
  output logic             dout,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy
);

  // Fill and run counters share one width; LOSS_THR never exceeds WIDTH.
  localparam int RUN_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GEN    = 2'd1;
  localparam logic [1:0] S_SYNC   = 2'd2;
  localparam logic [1:0] S_LOCKED = 2'd3;

  localparam logic [RUN_W-1:0] FILL_MAX = RUN_W'(WIDTH);
  localparam logic [RUN_W-1:0] LOSS_MAX = RUN_W'(LOSS_THR);
  localparam logic [WIDTH-1:0] Q_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [WIDTH-1:0] q;
  logic [RUN_W-1:0] fill_cnt;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_nxt;
  logic             fb;
  logic             mismatch;

  // Error counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // An all-zero LFSR never leaves zero, so a zero seed is replaced by 1.
  function automatic logic [WIDTH-1:0] seed_fix(input logic [WIDTH-1:0] s);
    return (s == '0) ? Q_ONE : s;
  endfunction

  assign fb       = ^(q & TAPS);
  assign mismatch = din ^ fb;
  assign run_nxt  = run_cnt + 1'b1;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      q        <= Q_ONE;
      dout     <= 1'b0;
      locked   <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= '0;
      fill_cnt <= '0;
      run_cnt  <= '0;
    end else begin
      err <= 1'b0;
      if (start) begin
        // start outranks en and seed_load in every state.
        if (state == S_IDLE) begin
          if (mode) begin
            state    <= S_SYNC;
            err_cnt  <= '0;
            fill_cnt <= '0;
            run_cnt  <= '0;
          end else begin
            state <= S_GEN;
          end
        end else begin
          state  <= S_IDLE;
          locked <= 1'b0;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (seed_load) q <= seed_fix(seed);
          end
          S_GEN: begin
            if (seed_load) begin
              q <= seed_fix(seed);
            end else if (en) begin
              dout <= fb;
              q    <= {q[WIDTH-2:0], fb};
            end
          end
          S_SYNC: begin
            if (fill_cnt == FILL_MAX) begin
              // q now holds WIDTH received bits; this edge locks regardless
              // of en, and still takes din so the stream stays aligned.
              state   <= S_LOCKED;
              locked  <= 1'b1;
              run_cnt <= '0;
              if (en) q <= {q[WIDTH-2:0], din};
            end else if (en) begin
              q        <= {q[WIDTH-2:0], din};
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
          S_LOCKED: begin
            if (en) begin
              // Self-synchronising: the received bit, not the prediction,
              // is shifted in.
              q <= {q[WIDTH-2:0], din};
              if (mismatch) begin
                err     <= 1'b1;
                err_cnt <= sat_inc(err_cnt);
                if (run_nxt == LOSS_MAX) begin
                  state    <= S_SYNC;
                  locked   <= 1'b0;
                  fill_cnt <= '0;
                  run_cnt  <= '0;
                end else begin
                  run_cnt <= run_nxt;
                end
              end else begin
                run_cnt <= '0;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prbs_xor_gen_chk.sv
module tb_prbs_xor_gen_chk;

  localparam int         W    = 7;
  localparam logic [6:0] TAPS = 7'h60;
  localparam int         LOSS = 4;
  localparam int         CMAX = 65535;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        mode = 1'b0;
  logic        start = 1'b0;
  logic        seed_load = 1'b0;
  logic [6:0]  seed = '0;
  logic        din = 1'b0;

  logic        dout, locked, err, busy;
  logic [15:0] err_cnt;
  logic        dout2, locked2, err2, busy2;
  logic [1:0]  err_cnt2;

  int checks = 0;
  int failures = 0;

  // Reference sequences: gq is the ideal PRBS bit stream, rx the bits the
  // checker has received. Bit history, newest at the back.
  bit gq[$];
  bit rx[$];
  bit m_lk, m_err;
  int m_fill, m_run, m_cnt;
  logic exp_dout;

  prbs_xor_gen_chk #(.WIDTH(7), .TAPS(7'h60), .CNT_W(16), .LOSS_THR(4)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .start(start),
    .seed_load(seed_load), .seed(seed), .din(din),
    .dout(dout), .locked(locked), .err(err), .err_cnt(err_cnt), .busy(busy)
  );

  prbs_xor_gen_chk #(.WIDTH(7), .TAPS(7'h60), .CNT_W(2), .LOSS_THR(7)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .start(start),
    .seed_load(seed_load), .seed(seed), .din(din),
    .dout(dout2), .locked(locked2), .err(err2), .err_cnt(err_cnt2), .busy(busy2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Seed bit i is the bit produced i+1 steps before the first new one.
  task automatic seq_init(input logic [6:0] s);
    gq.delete();
    for (int i = W - 1; i >= 0; i--) gq.push_back(s[i]);
  endtask

  // Next PRBS bit: XOR of the bits 1+i steps back for each set tap i.
  function automatic bit gnext();
    bit p = 1'b0;
    for (int i = 0; i < W; i++)
      if (TAPS[i]) p ^= gq[gq.size() - 1 - i];
    gq.push_back(p);
    return p;
  endfunction

  function automatic bit rx_predict();
    bit p = 1'b0;
    for (int i = 0; i < W; i++)
      if (TAPS[i]) p ^= rx[rx.size() - 1 - i];
    return p;
  endfunction

  task automatic model_chk_reset();
    rx.delete();
    m_lk = 1'b0; m_err = 1'b0;
    m_fill = 0; m_run = 0; m_cnt = 0;
  endtask

  // Checker behaviour for one clock edge, after a checker start.
  task automatic mstep(input bit e, input bit d);
    bit p;
    m_err = 1'b0;
    if (!m_lk && m_fill == W) begin
      m_lk = 1'b1;
      m_run = 0;
      if (e) rx.push_back(d);
    end else if (e) begin
      if (!m_lk) begin
        rx.push_back(d);
        m_fill++;
      end else begin
        p = rx_predict();
        rx.push_back(d);
        if (d != p) begin
          m_err = 1'b1;
          if (m_cnt < CMAX) m_cnt++;
          m_run++;
          if (m_run == LOSS) begin
            m_lk = 1'b0;
            m_fill = 0;
            m_run = 0;
          end
        end else begin
          m_run = 0;
        end
      end
    end
  endtask

  task automatic gstep(input bit e);
    en = e;
    tick();
    if (e) exp_dout = gnext();
    chk("gen_dout", 32'(dout), 32'(exp_dout));
  endtask

  task automatic feed(input bit e, input bit inv);
    bit d;
    if (e) d = gnext() ^ inv;
    else   d = 1'($urandom);
    en = e;
    din = d;
    tick();
    mstep(e, d);
    chk("chk_locked", 32'(locked), 32'(m_lk));
    chk("chk_err", 32'(err), 32'(m_err));
    chk("chk_cnt", 32'(err_cnt), 32'(m_cnt));
  endtask

  initial begin
    logic [7:0] cap;
    logic [6:0] cap7;
    int ones;
    int n;
    bit e;

    // Reset state
    #2;
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cnt", 32'(err_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    #10 rst_n = 1'b1;

    // Zero seed becomes 1; first 8 generator bits
    seed_load = 1'b1; seed = 7'h00;
    tick();
    seed_load = 1'b0;
    start = 1'b1; mode = 1'b0;
    tick();
    start = 1'b0;
    chk("gen_busy", 32'(busy), 32'd1);
    seq_init(7'h01);
    exp_dout = 1'b0;
    for (int i = 0; i < 8; i++) begin
      gstep(1'b1);
      cap[i] = dout;
    end
    chk("gen_first8", 32'(cap), 32'h60);

    // Reseed in GEN: dout holds that cycle
    seed_load = 1'b1; seed = 7'h01; en = 1'b1;
    tick();
    seed_load = 1'b0;
    chk("seed_hold_dout", 32'(dout), 32'(exp_dout));
    seq_init(7'h01);

    // Full period with random enable gaps
    ones = 0; n = 0;
    while (n < 127) begin
      e = ($urandom_range(0, 3) != 0);
      gstep(e);
      if (e) begin
        n++;
        ones += int'(dout);
      end
    end
    chk("period_ones", 32'(ones), 32'd64);
    for (int i = 0; i < 7; i++) begin
      gstep(1'b1);
      cap7[i] = dout;
    end
    chk("period_repeat", 32'(cap7), 32'h60);

    // Stop the generator
    en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("stop_busy", 32'(busy), 32'd0);

    // Checker start; mode change afterwards must be ignored
    mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; mode = 1'b0;
    chk("chk_start_busy", 32'(busy), 32'd1);
    chk("chk_start_cnt", 32'(err_cnt), 32'd0);
    chk("chk_start_locked", 32'(locked), 32'd0);
    seq_init(7'h5A);
    model_chk_reset();
    for (int i = 0; i < 8; i++) feed(1'b1, 1'b0);
    chk("lock_latency", 32'(locked), 32'd1);

    // 500 clean bits, random enable
    n = 0;
    while (n < 500) begin
      e = ($urandom_range(0, 4) != 0);
      feed(e, 1'b0);
      if (e) n++;
    end
    chk("clean_cnt", 32'(err_cnt), 32'd0);

    // Isolated flips: each also corrupts the two later predictions that tap
    // it (x^7 and x^6), so 3 flips give 9 counted mismatches.
    for (int i = 0; i < 60; i++) feed(1'b1, (i == 10 || i == 30 || i == 50));
    chk("iso_cnt", 32'(err_cnt), 32'd9);
    chk("iso_locked", 32'(locked), 32'd1);

    // Four consecutive flips force resync, then relock
    for (int i = 0; i < 30; i++) feed(1'b1, (i < 4));
    chk("loss_cnt", 32'(err_cnt), 32'd13);
    chk("relock", 32'(locked), 32'd1);

    // start while locked returns to IDLE, err_cnt retained
    en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("idle_locked", 32'(locked), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_cnt_hold", 32'(err_cnt), 32'd13);

    // New checker start clears err_cnt; saturation on the CNT_W=2 instance
    mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; mode = 1'b0;
    chk("restart_cnt", 32'(err_cnt), 32'd0);
    chk("restart_cnt2", 32'(err_cnt2), 32'd0);
    model_chk_reset();
    for (int i = 0; i < 8; i++) feed(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) feed(1'b1, 1'b1);
    chk("sat_cnt2", 32'(err_cnt2), 32'd3);
    chk("sat_locked2", 32'(locked2), 32'd1);
    chk("sat_err2", 32'(err2), 32'd1);

    // Asynchronous reset mid-LOCKED
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dout", 32'(dout), 32'd0);
    chk("arst_locked", 32'(locked), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_cnt", 32'(err_cnt), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_locked2", 32'(locked2), 32'd0);
    chk("arst_cnt2", 32'(err_cnt2), 32'd0);
    chk("arst_busy2", 32'(busy2), 32'd0);
    #3 rst_n = 1'b1;
    en = 1'b1;
    tick();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_dout", 32'(dout), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
